// File: rtl/inbuf_rd_arbiter_pkg.sv
// Shared definitions for the input-buffer read path: frame FSM states,
// return-tag owner encoding and the buffer geometry used by the input buffer.
package inbuf_rd_arbiter_pkg;

    localparam int INBUF_ADDR_W = 17;
    localparam int INBUF_DATA_W = 24;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        CNN_ACTIVE = 1'b1
    } frame_state_t;

    typedef enum logic {
        OWNER_LCD = 1'b0,
        OWNER_CNN = 1'b1
    } owner_t;

endpackage

// File: rtl/inbuf_rd_tag_pipe.sv
// Return-tag delay line: carries (valid, owner) of each granted read for
// RD_LAT cycles so the read data can be steered back to its requester.
module inbuf_rd_tag_pipe
    import inbuf_rd_arbiter_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_valid,
    input  owner_t i_owner,
    output logic   o_valid,
    output owner_t o_owner
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] own_q;

    // Shift tags one stage per cycle; reset drops every read in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q[0] <= i_valid;
            own_q[0] <= i_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
            end
        end
    end

    assign o_valid = vld_q[RD_LAT-1];
    assign o_owner = owner_t'(own_q[RD_LAT-1]);

endmodule

// File: rtl/inbuf_rd_arbiter.sv
// Read-port arbiter for the input frame buffer, shared by the LCD refresh
// path and the CNN window reader. LCD has priority, but CNN is guaranteed a
// slot after MAX_LCD_RUN back-to-back LCD grants while it waits.
// Optional build macro INBUF_ARB_STAT_EN adds per-requester grant counters.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  WAIT_FRAME | no frame for the CNN; only LCD reads are served
//  CNN_ACTIVE | frame window open; CNN and LCD reads are arbitrated
module inbuf_rd_arbiter
    import inbuf_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W      = INBUF_ADDR_W,
    parameter int DATA_W      = INBUF_DATA_W,
    parameter int RD_LAT      = 2,
    parameter int MAX_LCD_RUN = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_cnn_done,
    input  logic              i_lcd_req,
    input  logic [ADDR_W-1:0] i_lcd_addr,
    output logic              o_lcd_gnt,
    output logic              o_lcd_rvalid,
    output logic [DATA_W-1:0] o_lcd_rdata,
    input  logic              i_cnn_req,
    input  logic [ADDR_W-1:0] i_cnn_addr,
    output logic              o_cnn_gnt,
    output logic              o_cnn_rvalid,
    output logic [DATA_W-1:0] o_cnn_rdata,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_cnn_busy
`ifdef INBUF_ARB_STAT_EN
    ,
    output logic [31:0]       o_lcd_rd_cnt,
    output logic [31:0]       o_cnn_rd_cnt
`endif
);

    localparam int              RUN_W   = $clog2(MAX_LCD_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_LCD_RUN);

    frame_state_t      state_q;
    logic [RUN_W-1:0]  run_q;
    logic              cnn_elig;
    logic              lcd_win;
    logic              cnn_win;
    logic [ADDR_W-1:0] rd_addr;
    logic              tag_valid;
    owner_t            tag_owner;
    logic [DATA_W-1:0] lcd_rdata_q;
    logic [DATA_W-1:0] cnn_rdata_q;

    // Grant decision; gated by reset so nothing is issued while held in reset.
    always_comb begin
        cnn_elig = (state_q == CNN_ACTIVE) && i_cnn_req;
        lcd_win  = i_rst_n && i_lcd_req && !(cnn_elig && (run_q == RUN_MAX));
        cnn_win  = i_rst_n && cnn_elig && !lcd_win;
        rd_addr  = '0;
        if (lcd_win) begin
            rd_addr = i_lcd_addr;
        end else if (cnn_win) begin
            rd_addr = i_cnn_addr;
        end
    end

    assign o_lcd_gnt = lcd_win;
    assign o_cnn_gnt = cnn_win;
    assign o_rd_en   = lcd_win | cnn_win;
    assign o_rd_addr = rd_addr;

    // Frame FSM plus the LCD run counter that bounds CNN waiting time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= WAIT_FRAME;
            o_cnn_busy <= 1'b0;
            run_q      <= '0;
        end else begin
            case (state_q)
                WAIT_FRAME: begin
                    if (i_start) begin
                        state_q    <= CNN_ACTIVE;
                        o_cnn_busy <= 1'b1;
                    end
                end
                CNN_ACTIVE: begin
                    // a new frame arriving with done keeps the window open
                    if (i_cnn_done && !i_start) begin
                        state_q    <= WAIT_FRAME;
                        o_cnn_busy <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= WAIT_FRAME;
                    o_cnn_busy <= 1'b0;
                end
            endcase

            if (cnn_win || !cnn_elig) begin
                run_q <= '0;
            end else if (lcd_win && (run_q != RUN_MAX)) begin
                run_q <= run_q + 1'b1;
            end
        end
    end

    inbuf_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (o_rd_en),
        .i_owner (lcd_win ? OWNER_LCD : OWNER_CNN),
        .o_valid (tag_valid),
        .o_owner (tag_owner)
    );

    assign o_lcd_rvalid = tag_valid && (tag_owner == OWNER_LCD);
    assign o_cnn_rvalid = tag_valid && (tag_owner == OWNER_CNN);

    // Remember each owner's last word so its rdata holds between returns.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lcd_rdata_q <= '0;
            cnn_rdata_q <= '0;
        end else begin
            if (o_lcd_rvalid) begin
                lcd_rdata_q <= i_rd_data;
            end
            if (o_cnn_rvalid) begin
                cnn_rdata_q <= i_rd_data;
            end
        end
    end

    assign o_lcd_rdata = o_lcd_rvalid ? i_rd_data : lcd_rdata_q;
    assign o_cnn_rdata = o_cnn_rvalid ? i_rd_data : cnn_rdata_q;

`ifdef INBUF_ARB_STAT_EN
    // Per-frame grant statistics; a new frame restarts both counts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lcd_rd_cnt <= '0;
            o_cnn_rd_cnt <= '0;
        end else if (i_start) begin
            o_lcd_rd_cnt <= '0;
            o_cnn_rd_cnt <= '0;
        end else begin
            if (lcd_win) begin
                o_lcd_rd_cnt <= o_lcd_rd_cnt + 32'd1;
            end
            if (cnn_win) begin
                o_cnn_rd_cnt <= o_cnn_rd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inbuf_rd_arbiter.sv
// Bench for inbuf_rd_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based model of the arbitration rules.
module tb_inbuf_rd_arbiter;

    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 24;
    localparam int RD_LAT  = 2;
    localparam int MAX_RUN = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, cnn_done;
    logic              lcd_req, cnn_req;
    logic [ADDR_W-1:0] lcd_addr, cnn_addr;
    logic [DATA_W-1:0] rd_data;
    logic              lcd_gnt, cnn_gnt, lcd_rvalid, cnn_rvalid, rd_en, cnn_busy;
    logic [DATA_W-1:0] lcd_rdata, cnn_rdata;
    logic [ADDR_W-1:0] rd_addr;
`ifdef INBUF_ARB_STAT_EN
    logic [31:0]       lcd_rd_cnt, cnn_rd_cnt;
`endif

    inbuf_rd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_LCD_RUN(MAX_RUN)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cnn_done(cnn_done),
        .i_lcd_req(lcd_req), .i_lcd_addr(lcd_addr), .o_lcd_gnt(lcd_gnt),
        .o_lcd_rvalid(lcd_rvalid), .o_lcd_rdata(lcd_rdata),
        .i_cnn_req(cnn_req), .i_cnn_addr(cnn_addr), .o_cnn_gnt(cnn_gnt),
        .o_cnn_rvalid(cnn_rvalid), .o_cnn_rdata(cnn_rdata),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_cnn_busy(cnn_busy)
`ifdef INBUF_ARB_STAT_EN
        , .o_lcd_rd_cnt(lcd_rd_cnt), .o_cnn_rd_cnt(cnn_rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    bit          m_busy = 0;
    int          m_streak = 0;
    int          q_due[$];
    bit          q_cnn[$];
    logic [DATA_W-1:0] m_lcd_last = '0, m_cnn_last = '0;

    // values sampled in the most recent cycle
    logic obs_lcd_gnt, obs_cnn_gnt, obs_lcd_rv, obs_cnn_rv, obs_busy;
    logic [ADDR_W-1:0] obs_addr;
    logic [DATA_W-1:0] obs_lcd_rdata, obs_cnn_rdata, drv_rd_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive data, sample mid-cycle, compare, advance model.
    task automatic step();
        bit cnn_elig, e_lcd, e_cnn, e_rv_l, e_rv_c;
        logic [ADDR_W-1:0] e_addr;
        rd_data     = DATA_W'($urandom);
        drv_rd_data = rd_data;
        #1;
        obs_lcd_gnt = lcd_gnt; obs_cnn_gnt = cnn_gnt;
        obs_lcd_rv  = lcd_rvalid; obs_cnn_rv = cnn_rvalid;
        obs_busy    = cnn_busy; obs_addr = rd_addr;
        obs_lcd_rdata = lcd_rdata; obs_cnn_rdata = cnn_rdata;

        e_lcd = 0; e_cnn = 0; e_rv_l = 0; e_rv_c = 0; e_addr = '0;
        if (!rst_n) begin
            q_due.delete(); q_cnn.delete();
            m_busy = 0; m_streak = 0; m_lcd_last = '0; m_cnn_last = '0;
        end else begin
            cnn_elig = m_busy && cnn_req;
            e_lcd = lcd_req && !(cnn_elig && m_streak >= MAX_RUN);
            e_cnn = cnn_elig && !e_lcd;
            if (e_lcd) e_addr = lcd_addr;
            else if (e_cnn) e_addr = cnn_addr;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                if (q_cnn[0]) begin e_rv_c = 1; m_cnn_last = rd_data; end
                else          begin e_rv_l = 1; m_lcd_last = rd_data; end
                void'(q_due.pop_front()); void'(q_cnn.pop_front());
            end
        end

        check("lcd_gnt", obs_lcd_gnt, e_lcd);
        check("cnn_gnt", obs_cnn_gnt, e_cnn);
        check("rd_en", rd_en, e_lcd | e_cnn);
        check("rd_addr", obs_addr, e_addr);
        check("cnn_busy", obs_busy, m_busy);
        check("lcd_rvalid", obs_lcd_rv, e_rv_l);
        check("cnn_rvalid", obs_cnn_rv, e_rv_c);
        check("lcd_rdata", obs_lcd_rdata, m_lcd_last);
        check("cnn_rdata", obs_cnn_rdata, m_cnn_last);

        if (rst_n) begin
            if (e_lcd || e_cnn) begin
                q_due.push_back(cyc + RD_LAT);
                q_cnn.push_back(e_cnn);
            end
            if (!cnn_elig || e_cnn) m_streak = 0;
            else if (e_lcd) m_streak = (m_streak < MAX_RUN) ? m_streak + 1 : MAX_RUN;
            if (start) m_busy = 1;
            else if (cnn_done) m_busy = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; start = 0; cnn_done = 0;
        lcd_req = 0; cnn_req = 0; lcd_addr = '0; cnn_addr = '0; rd_data = '0;
        @(negedge clk);

        // held in reset with a request present: nothing issued
        lcd_req = 1; lcd_addr = 17'h00abc;
        repeat (3) step();
        check("rst_gnt", obs_lcd_gnt, 1'b0);
        lcd_req = 0;
        rst_n = 1;
        step();

        // single LCD read, data back RD_LAT cycles later
        lcd_req = 1; lcd_addr = 17'h00010;
        step();
        check("r21_gnt", obs_lcd_gnt, 1'b1);
        check("r21_addr", obs_addr, 17'h00010);
        lcd_req = 0;
        step();
        check("r21_early", obs_lcd_rv, 1'b0);
        step();
        check("r21_rvalid", obs_lcd_rv, 1'b1);
        check("r21_rdata", obs_lcd_rdata, drv_rd_data);

        // CNN ignored until a frame starts
        cnn_req = 1; cnn_addr = 17'h01234;
        step();
        check("r22_nogrant", obs_cnn_gnt, 1'b0);
        start = 1;
        step();
        start = 0;
        step();
        check("r22_busy", obs_busy, 1'b1);
        check("r22_gnt", obs_cnn_gnt, 1'b1);
        check("r22_addr", obs_addr, 17'h01234);
        cnn_req = 0;
        repeat (2) step();

        // start and done together keep the window open
        start = 1; cnn_done = 1;
        step();
        start = 0; cnn_done = 0;
        step();
        check("r24_busy", obs_busy, 1'b1);

        // CNN read issued just before done still returns
        cnn_req = 1; cnn_addr = 17'h00055;
        step();
        check("r25_gnt", obs_cnn_gnt, 1'b1);
        cnn_req = 0; cnn_done = 1;
        step();
        cnn_done = 0;
        step();
        check("r25_rvalid", obs_cnn_rv, 1'b1);
        check("r25_busy", obs_busy, 1'b0);

        // both requesting: MAX_RUN LCD grants then one CNN grant, repeating
        start = 1;
        step();
        start = 0;
        step();
        lcd_req = 1; cnn_req = 1;
        for (int k = 1; k <= 3 * (MAX_RUN + 1); k++) begin
            step();
            check("r23_cnn_slot", obs_cnn_gnt, (k % (MAX_RUN + 1)) == 0);
            if (obs_lcd_gnt) lcd_addr = ADDR_W'($urandom);
            if (obs_cnn_gnt) cnn_addr = ADDR_W'($urandom);
        end
        lcd_req = 0; cnn_req = 0;
        repeat (3) step();

        // random traffic honouring hold-until-granted
        for (int i = 0; i < 400; i++) begin
            if (!lcd_req || obs_lcd_gnt) begin
                lcd_req = ($urandom % 3) != 0; lcd_addr = ADDR_W'($urandom);
            end
            if (!cnn_req || obs_cnn_gnt) begin
                cnn_req = ($urandom % 3) != 0; cnn_addr = ADDR_W'($urandom);
            end
            start    = ($urandom % 40) == 0;
            cnn_done = ($urandom % 25) == 0;
            step();
        end
        lcd_req = 0; cnn_req = 0; start = 0; cnn_done = 0;
        repeat (4) step();

        // reset with reads in flight: they must never return
        start = 1;
        step();
        start = 0;
        lcd_req = 1; cnn_req = 1;
        step();
        step();
        check("r26_inflight", obs_lcd_gnt, 1'b1);
        rst_n = 0;
        step();
        check("r26_rst_rv", obs_lcd_rv | obs_cnn_rv, 1'b0);
        lcd_req = 0; cnn_req = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < RD_LAT + 2; i++) begin
            step();
            check("r26_no_rv", obs_lcd_rv | obs_cnn_rv, 1'b0);
        end
`ifdef INBUF_ARB_STAT_EN
        check("r26_lcd_cnt", lcd_rd_cnt, 32'd0);
        check("r26_cnn_cnt", cnn_rd_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inbuf_rd_arbiter.md
INBUF_RD_ARBITER -- requirements
Module: inbuf_rd_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 17, buffer word address width; DATA_W, default 24, read data width (RGB888); RD_LAT, default 2, buffer read latency in cycles (range 1-4); MAX_LCD_RUN, default 8, maximum consecutive LCD grants while CNN waits.
REQ-002 Ports SHALL be, clock and reset first:
- i_clk  in  1  single 100MHz clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  frame-ready pulse from the input buffer.
- i_cnn_done  in  1  CNN finished current frame, pulse.
- i_lcd_req  in  1  LCD read request.
- i_lcd_addr  in  ADDR_W  LCD read address.
- o_lcd_gnt  out  1  LCD request accepted this cycle.
- o_lcd_rvalid  out  1  LCD read data valid.
- o_lcd_rdata  out  DATA_W  LCD read data.
- i_cnn_req  in  1  CNN window read request.
- i_cnn_addr  in  ADDR_W  CNN read address.
- o_cnn_gnt  out  1  CNN request accepted this cycle.
- o_cnn_rvalid  out  1  CNN read data valid.
- o_cnn_rdata  out  DATA_W  CNN read data.
- o_rd_en  out  1  buffer read enable.
- o_rd_addr  out  ADDR_W  buffer read address.
- i_rd_data  in  DATA_W  buffer read data, valid RD_LAT cycles after o_rd_en.
- o_cnn_busy  out  1  CNN frame window open.

Function
REQ-003 Frame FSM SHALL have states WAIT_FRAME and CNN_ACTIVE; o_cnn_busy=1 exactly in CNN_ACTIVE.
REQ-004 WAIT_FRAME -> CNN_ACTIVE on i_start; CNN_ACTIVE -> WAIT_FRAME on i_cnn_done without i_start.
REQ-005 i_start and i_cnn_done in the same cycle SHALL leave/put the FSM in CNN_ACTIVE (new frame wins); i_start while already CNN_ACTIVE SHALL be ignored.
REQ-006 CNN requests SHALL be eligible only in CNN_ACTIVE; LCD requests SHALL be eligible in both states.
REQ-007 At most one grant per cycle; o_lcd_gnt/o_cnn_gnt SHALL be combinational from current requests, FSM state and run counter.
REQ-008 Priority: LCD wins when both eligible, unless run counter equals MAX_LCD_RUN, then CNN wins.
REQ-009 Run counter SHALL increment on each LCD grant while an eligible CNN request is pending, saturate at MAX_LCD_RUN, and clear on any CNN grant or any cycle without a pending eligible CNN request.
REQ-010 o_rd_en SHALL equal (o_lcd_gnt | o_cnn_gnt); o_rd_addr SHALL be the granted requester's address, 0 when idle.
REQ-011 A requester SHALL hold req and addr stable until granted; a new address may be presented the cycle after a grant (one read per cycle sustained).
REQ-012 A grant tag (valid, owner) SHALL travel an RD_LAT-deep shift register; at its output the owner's rvalid asserts for one cycle with rdata=i_rd_data.
REQ-013 Return order SHALL equal grant order; rvalid appears exactly RD_LAT cycles after the corresponding gnt.
REQ-014 Non-owner rdata SHALL hold its last value; rvalid of the non-owner SHALL be 0.
REQ-015 CNN reads granted before i_cnn_done SHALL still return their data after the FSM leaves CNN_ACTIVE.

Reset
REQ-016 On i_rst_n low: FSM=WAIT_FRAME, run counter=0, tag pipeline cleared, all gnt/rvalid/o_rd_en/o_cnn_busy=0, rdata and o_rd_addr=0.
REQ-017 Reads in flight at reset SHALL be discarded; no rvalid SHALL appear after reset release for pre-reset grants.

Configuration
REQ-018 Macro INBUF_ARB_STAT_EN SHALL, when defined, add outputs o_lcd_rd_cnt and o_cnn_rd_cnt (32-bit, wrapping, reset 0) counting grants per requester, cleared on i_start; when undefined, those ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-019 Shared package SHALL hold FSM state encoding, owner tag encoding (LCD=0, CNN=1) and default ADDR_W/DATA_W constants reused by the input buffer.
REQ-020 The return tag shift register SHALL be sub-module inbuf_rd_tag_pipe (parameter RD_LAT).

Verification
REQ-021 Reset then LCD req addr 0x00010, RD_LAT=2 -> gnt cycle 0, o_rd_addr=0x00010, o_lcd_rvalid cycle 2 with i_rd_data.
REQ-022 CNN req in WAIT_FRAME -> no o_cnn_gnt; pulse i_start -> o_cnn_busy=1 next cycle, CNN granted.
REQ-023 Both continuously requesting, MAX_LCD_RUN=8 -> 8 LCD grants, 1 CNN grant, repeating; CNN never starves.
REQ-024 i_start and i_cnn_done same cycle in CNN_ACTIVE -> o_cnn_busy stays 1.
REQ-025 CNN granted at cycle N, i_cnn_done at N+1 -> o_cnn_rvalid still at N+2.
REQ-026 Assert reset with 2 reads in flight -> no rvalid after release; with INBUF_ARB_STAT_EN, counters read 0.
